// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN tile scheduler slice.
package cnn_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, FINAL, DONE} sched_state_e;

  localparam int PE_CREDITS_DEF = 4;
endpackage

// File: rtl/cnn_credit_cnt.sv
// Saturating credit counter tracking free window slots in the PE input FIFO.
module cnn_credit_cnt #(
  parameter int PE_CREDITS = 4,
  localparam int CW = $clog2(PE_CREDITS + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic dec,
  input  logic inc,
  output logic low
);
  localparam logic [CW-1:0] MAX = CW'(PE_CREDITS);

  logic [CW-1:0] credits;

  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= MAX;
    end else if (dec && !inc && credits != '0) begin
      credits <= credits - CW'(1);
    end else if (inc && !dec && credits != MAX) begin
      credits <= credits + CW'(1);
    end
  end

  // Threshold 1: a window requested last cycle may still land after stall rises.
  assign low = (credits <= CW'(1));

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(dec && !inc && credits == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(inc && !dec && credits == MAX));
endmodule

// File: rtl/cnn_tile_sched.sv
// Layer sequencer for CNNBuffer: per-tile req/req_final, credit-based window throttling, done/error.
module cnn_tile_sched
  import cnn_pkg::*;
#(
  parameter int TILE_CNT_W = 8,
  parameter int WIN_CNT_W  = 16,
  parameter int PE_CREDITS = PE_CREDITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [TILE_CNT_W-1:0] cfg_tiles,
  input  logic [WIN_CNT_W-1:0]  cfg_win_per_tile,
  output logic                  busy,
  output logic                  done,
  output logic                  err_win_cnt,
  output logic                  buf_req,
  output logic                  buf_req_final,
  input  logic                  buf_window_valid,
  input  logic                  buf_window_finish,
  output logic                  buf_window_stall,
  input  logic                  pe_credit_ret,
  output logic [TILE_CNT_W-1:0] tile_idx
);
  sched_state_e          state, state_nxt;
  logic [TILE_CNT_W-1:0] tiles_q;
  logic [WIN_CNT_W-1:0]  win_cfg_q;
  logic [WIN_CNT_W-1:0]  win_cnt;
  logic                  fin_seen;
  logic                  cred_low;
  logic                  last_tile;

  cnn_credit_cnt #(.PE_CREDITS(PE_CREDITS)) u_credit (
    .clk (clk),
    .rst (rst),
    .dec (buf_window_valid),
    .inc (pe_credit_ret),
    .low (cred_low)
  );

  assign last_tile = (tile_idx == tiles_q - TILE_CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tiles_q     <= '0;
      win_cfg_q   <= '0;
      tile_idx    <= '0;
      win_cnt     <= '0;
      err_win_cnt <= 1'b0;
      fin_seen    <= 1'b0;
    end else begin
      state <= state_nxt;
      // The last window_valid trails finish by a cycle, so FINAL waits one extra cycle.
      fin_seen <= (state == RUN) && buf_window_finish;
      case (state)
        IDLE: if (start) begin
          tiles_q     <= cfg_tiles;
          win_cfg_q   <= cfg_win_per_tile;
          tile_idx    <= '0;
          err_win_cnt <= 1'b0;
        end
        LOAD: win_cnt <= '0;
        RUN: if (buf_window_valid && win_cnt != '1) win_cnt <= win_cnt + WIN_CNT_W'(1);
        FINAL: begin
          if (win_cnt != win_cfg_q) err_win_cnt <= 1'b1;
          if (!last_tile) tile_idx <= tile_idx + TILE_CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt        = state;
    busy             = 1'b0;
    done             = 1'b0;
    buf_req          = 1'b0;
    buf_req_final    = 1'b0;
    buf_window_stall = 1'b1;
    case (state)
      IDLE: if (start) state_nxt = (cfg_tiles == '0) ? DONE : LOAD;
      LOAD: begin
        busy      = 1'b1;
        buf_req   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        busy             = 1'b1;
        buf_window_stall = cred_low;
        if (fin_seen) state_nxt = FINAL;
      end
      FINAL: begin
        busy          = 1'b1;
        buf_req_final = 1'b1;
        state_nxt     = last_tile ? DONE : LOAD;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cnn_tile_sched.sv
// Scoreboard bench for cnn_tile_sched with behavioural CNNBuffer and PE FIFO models.
module tb_cnn_tile_sched;
  localparam int PEC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cfg_tiles = '0;
  logic [15:0] cfg_win = '0;
  logic        busy, done, err_win_cnt, buf_req, buf_req_final, buf_window_stall;
  logic        buf_window_valid = 1'b0, buf_window_finish = 1'b0, pe_credit_ret = 1'b0;
  logic [7:0]  tile_idx;

  always #5 clk = ~clk;

  cnn_tile_sched #(.TILE_CNT_W(8), .WIN_CNT_W(16), .PE_CREDITS(PEC)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .cfg_tiles         (cfg_tiles),
    .cfg_win_per_tile  (cfg_win),
    .busy              (busy),
    .done              (done),
    .err_win_cnt       (err_win_cnt),
    .buf_req           (buf_req),
    .buf_req_final     (buf_req_final),
    .buf_window_valid  (buf_window_valid),
    .buf_window_finish (buf_window_finish),
    .buf_window_stall  (buf_window_stall),
    .pe_credit_ret     (pe_credit_ret),
    .tile_idx          (tile_idx)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Expected pulse sequence: kind 0=buf_req, 1=buf_req_final, 2=done
  typedef struct { int kind; int idx; logic err; } ev_t;
  ev_t sbq[$];

  // CNNBuffer model: one kernel request per unstalled cycle, window_valid one cycle later.
  int   act_n [256];
  int   rem = 0;
  logic issue;
  assign issue = (rem > 0) && !buf_window_stall;

  always @(posedge clk) begin
    if (rst) begin
      rem               <= 0;
      buf_window_valid  <= 1'b0;
      buf_window_finish <= 1'b0;
    end else begin
      buf_window_valid <= issue;
      if (buf_req) begin
        rem               <= act_n[tile_idx];
        buf_window_finish <= (act_n[tile_idx] == 0);
      end else if (issue) begin
        rem <= rem - 1;
        if (rem == 1) buf_window_finish <= 1'b1;
      end
    end
  end

  // PE FIFO model: out_n windows held, each returned later as one credit pulse.
  int   out_n = 0;
  int   ret_pct = 100;
  int   win_seen = 0;
  logic force_ret = 1'b0;
  int   n_nxt;
  assign n_nxt = out_n + (buf_window_valid ? 1 : 0) - (pe_credit_ret ? 1 : 0);

  always @(posedge clk) begin
    if (rst) begin
      out_n         <= 0;
      pe_credit_ret <= 1'b0;
    end else begin
      out_n         <= n_nxt;
      pe_credit_ret <= (n_nxt > 0) && (force_ret || ($urandom_range(0, 99) < ret_pct));
      if (buf_window_valid) win_seen <= win_seen + 1;
    end
  end

  // Monitor
  int   mon_kind;
  ev_t  mon_ev;
  always @(negedge clk) begin
    if (!rst) begin
      // A window may only land while the PE FIFO has a free slot.
      if (buf_window_valid) chk("credit_bound", (out_n < PEC), 1);
      if (!busy) chk("idle_stall", buf_window_stall, 1);
      if (buf_req || buf_req_final || done) begin
        chk("pulse_exclusive", int'(buf_req) + int'(buf_req_final) + int'(done), 1);
        mon_kind = buf_req ? 0 : (buf_req_final ? 1 : 2);
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got kind %0d want none", mon_kind);
        end else begin
          mon_ev = sbq.pop_front();
          chk("ev_kind", mon_kind, mon_ev.kind);
          if (mon_kind != 2) chk("ev_tile_idx", tile_idx, mon_ev.idx);
          if (mon_kind != 1) chk("ev_err", err_win_cnt, mon_ev.err);
        end
      end
      if (sbq.size() != 0) chk("busy_pending", busy, 1);
    end
  end

  task automatic pulse_start(input int t, input int w);
    start     = 1'b1;
    cfg_tiles = 8'(t);
    cfg_win   = 16'(w);
    @(posedge clk);
    #1;
    start     = 1'b0;
    cfg_tiles = 8'($urandom);
    cfg_win   = 16'($urandom);
  endtask

  task automatic wait_idle(input string name);
    logic ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, 1);
    if (!ok) sbq.delete();
    @(posedge clk);
    #1;
  endtask

  // mode 0: buffer emits exactly cfg windows; 1: random +-1 jitter; 2: one short per tile
  task automatic run_layer(input int t, input int w, input int mode, input logic poke);
    logic err = 1'b0;
    int   d;
    for (int i = 0; i < t; i++) begin
      d = 0;
      if (mode == 1) d = $urandom_range(0, 3) - 1;
      if (mode == 2) d = -1;
      if (d > 1) d = 0;
      act_n[i] = (w + d < 0) ? 0 : w + d;
    end
    pulse_start(t, w);
    for (int i = 0; i < t; i++) begin
      sbq.push_back('{0, i, err});
      sbq.push_back('{1, i, 1'b0});
      err = err | (act_n[i] != w);
    end
    sbq.push_back('{2, 0, err});
    if (poke && t > 0) begin
      repeat (2) @(posedge clk);
      #1;
      pulse_start($urandom_range(0, 255), $urandom_range(0, 65535));
    end
    wait_idle("layer_timeout");
    chk("err_sticky_idle", err_win_cnt, err);
  endtask

  // Starting from an empty PE FIFO with no credit returns, exactly PEC windows get through.
  // Stall stays up until credits exceed 1, so a single return frees nothing; a second
  // return lets two more windows through (one already in flight as stall rises).
  task automatic credit_probe();
    int   w0;
    logic ok = 1'b0;
    ret_pct = 100;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (out_n == 0 && !pe_credit_ret) begin
        ok = 1'b1;
        break;
      end
    end
    chk("pe_drain", ok, 1);
    ret_pct = 0;
    @(posedge clk);
    #1;
    act_n[0] = 12;
    w0 = win_seen;
    pulse_start(1, 12);
    sbq.push_back('{0, 0, 1'b0});
    sbq.push_back('{1, 0, 1'b0});
    sbq.push_back('{2, 0, 1'b0});
    repeat (30) @(posedge clk);
    #1;
    chk("windows_no_return", win_seen - w0, PEC);
    chk("stall_held", buf_window_stall, 1);
    for (int r = 0; r < 2; r++) begin
      force_ret = 1'b1;
      @(posedge clk);
      #1;
      force_ret = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk(r == 0 ? "windows_one_return" : "windows_two_returns", win_seen - w0,
          r == 0 ? PEC : PEC + 2);
    end
    ret_pct = 100;
    wait_idle("probe_timeout");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", buf_req, 0);
    chk("rst_req_final", buf_req_final, 0);
    chk("rst_err", err_win_cnt, 0);
    chk("rst_tile_idx", tile_idx, 0);
    chk("rst_stall", buf_window_stall, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    ret_pct = 100;
    run_layer(2, 5, 0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      ret_pct = $urandom_range(20, 100);
      run_layer($urandom_range(1, 4), $urandom_range(1, 8), 1, 1'(k % 2));
    end

    ret_pct = 100;
    run_layer(2, 5, 2, 1'b1);

    // Zero-tile layer: done one cycle after start, error cleared, no buffer request.
    pulse_start(0, 7);
    sbq.push_back('{2, 0, 1'b0});
    @(negedge clk);
    chk("zero_tiles_done", done, 1);
    chk("zero_tiles_busy", busy, 1);
    wait_idle("zero_tiles_timeout");
    chk("zero_tiles_err", err_win_cnt, 0);

    credit_probe();

    // Reset in the RUN phase of tile 1.
    ret_pct = 100;
    for (int i = 0; i < 3; i++) act_n[i] = 6;
    pulse_start(3, 6);
    sbq.push_back('{0, 0, 1'b0});
    sbq.push_back('{1, 0, 1'b0});
    sbq.push_back('{0, 1, 1'b0});
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (tile_idx == 8'd1 && busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_tile1", ok, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_stall", buf_window_stall, 1);
    chk("midrst_tile_idx", tile_idx, 0);
    chk("midrst_req_final", buf_req_final, 0);
    chk("midrst_pending", sbq.size(), 0);
    sbq.delete();
    repeat (10) @(posedge clk);
    #1;
    credit_probe();

    ret_pct = 60;
    run_layer(3, 4, 1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
